// File: rtl/dmem_pkg.sv
// Shared address map and STAT bit layout for the data-side memory responder.
package dmem_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] SW_ADDR   = 32'hFFFF_0004;
    localparam logic [31:0] CYC_ADDR  = 32'hFFFF_0008;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_000C;

    localparam int STAT_MISALIGN = 0;
    localparam int STAT_UNMAPPED = 1;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: combinational read, rising-edge write, contents never reset.
module dmem_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read shares the write address, so a same-cycle read sees pre-write data.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Data RAM plus MMIO window (LED, switches, cycle counter, sticky STAT) for the core.
// Define DMEM_MMIO_EN to build the MMIO window; otherwise only RAM is mapped.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int OPERAND_LENGTH = 31,
    parameter int DEPTH_WORDS    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPERAND_LENGTH:0] memAddress,
    input  logic [OPERAND_LENGTH:0] writeDataMem,
    input  logic                    memRead,
    input  logic                    memWrite,
    output logic [OPERAND_LENGTH:0] readDataMem,
    input  logic [15:0]             switches,
    output logic [15:0]             leds
);

    localparam int W  = OPERAND_LENGTH + 1;
    localparam int AW = $clog2(DEPTH_WORDS);

    logic         access, misaligned, aligned, in_ram, mapped;
    logic         aligned_wr, ram_we;
    logic         err_misalign, err_unmapped;
    logic [W-1:0] ram_rdata;
    logic [1:0]   stat_d, stat_q;

    assign access     = memRead | memWrite;
    assign misaligned = memAddress[1:0] != 2'b00;
    assign aligned    = !misaligned;
    assign in_ram     = memAddress[W-1:AW+2] == RAM_BASE[W-1:AW+2];
    assign aligned_wr = memWrite && aligned;
    assign ram_we     = aligned_wr && in_ram && !rst;

`ifdef DMEM_MMIO_EN
    logic         is_led, is_sw, is_cyc, is_stat;
    logic [15:0]  leds_d, leds_q;
    logic [15:0]  sw_meta_d, sw_meta_q, sw_sync_d, sw_sync_q;
    logic [W-1:0] cyc_d, cyc_q;

    assign is_led  = memAddress == LED_ADDR;
    assign is_sw   = memAddress == SW_ADDR;
    assign is_cyc  = memAddress == CYC_ADDR;
    assign is_stat = memAddress == STAT_ADDR;
    assign mapped  = in_ram | is_led | is_sw | is_cyc | is_stat;
    assign leds    = leds_q;
`else
    logic unused_sw;

    assign mapped    = in_ram;
    assign leds      = '0;
    assign unused_sw = ^switches;
`endif

    assign err_misalign = access && misaligned;
    assign err_unmapped = access && aligned && !mapped;

    dmem_ram #(
        .WIDTH(W),
        .DEPTH(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (memAddress[AW+1:2]),
        .wdata(writeDataMem),
        .rdata(ram_rdata)
    );

    always_comb begin
        readDataMem = '0;
        if (memRead && aligned) begin
            if (in_ram) begin
                readDataMem = ram_rdata;
            end
`ifdef DMEM_MMIO_EN
            else if (is_led) begin
                readDataMem = {{(W-16){1'b0}}, leds_q};
            end else if (is_sw) begin
                readDataMem = {{(W-16){1'b0}}, sw_sync_q};
            end else if (is_cyc) begin
                readDataMem = cyc_q;
            end else if (is_stat) begin
                readDataMem = {{(W-2){1'b0}}, stat_q};
            end
`endif
        end
    end

    always_comb begin
        stat_d = stat_q;
`ifdef DMEM_MMIO_EN
        if (aligned_wr && is_stat) begin
            stat_d = stat_q & ~writeDataMem[1:0];
        end
`endif
        // Applied after the clear so a same-cycle set wins.
        if (err_misalign) stat_d[STAT_MISALIGN] = 1'b1;
        if (err_unmapped) stat_d[STAT_UNMAPPED] = 1'b1;
    end

`ifdef DMEM_MMIO_EN
    always_comb begin
        leds_d    = leds_q;
        cyc_d     = cyc_q + 1'b1;
        sw_meta_d = switches;
        sw_sync_d = sw_meta_q;
        if (aligned_wr && is_led) leds_d = writeDataMem[15:0];
        if (aligned_wr && is_cyc) cyc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q    <= '0;
            cyc_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            leds_q    <= leds_d;
            cyc_q     <= cyc_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Data-side responder for the single-cycle core's memory interface. It owns the word-addressed data RAM and a small memory-mapped I/O window (LED register, synchronised switches, cycle counter, sticky error status), answering the core's `memAddress` / `memRead` / `memWrite` / `writeDataMem` requests. Reads return data combinationally in the same cycle; writes commit on the rising clock edge.

## Interface
- `OPERAND_LENGTH`, 31: MSB index of the data/address width (32-bit words).
- `DEPTH_WORDS`, 256: RAM depth in 32-bit words; power of two, at most 1024.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `memAddress` input OPERAND_LENGTH+1: byte address from the core.
- `writeDataMem` input OPERAND_LENGTH+1: store data.
- `memRead` input 1: load request, valid the same cycle.
- `memWrite` input 1: store request, committed at the edge.
- `readDataMem` output OPERAND_LENGTH+1: load data, combinational.
- `switches` input 16: asynchronous board switches.
- `leds` output 16: LED register.

## Operation
- Address map (byte addresses):
  - RAM at 0x0000_0000 to DEPTH_WORDS*4-1; word index = `memAddress[log2(DEPTH_WORDS)+1:2]`.
  - LED at 0xFFFF_0000: read/write, low 16 bits used, upper bits read back as 0.
  - SW at 0xFFFF_0004: read-only, zero-extended synchronised switches.
  - CYC at 0xFFFF_0008: free-running 32-bit counter; any write clears it.
  - STAT at 0xFFFF_000C: bit0 = misaligned, bit1 = unmapped; these bits are write-1-to-clear, and all other bits read as 0.
- Access rules:
  - Misaligned access (`memAddress[1:0]` != 0 with `memRead` or `memWrite` asserted): no write occurs, the read returns 0, and STAT bit0 is set.
  - Unmapped aligned access: no write occurs, the read returns 0, and STAT bit1 is set.
  - A write to SW is silently ignored and is not an error.
  - `readDataMem` is 0 whenever `memRead` is low.
  - With `memRead` and `memWrite` both high, the write commits at the edge and `readDataMem` shows the pre-write contents.
- Counter: increments every cycle and wraps from 0xFFFF_FFFF to 0. When a CYC write occurs, the counter holds 0 for the next cycle and increments from there.
- STAT: if an error is set and cleared in the same cycle, set wins.
- Switches: pass through a two-flop synchroniser before being readable.

## Timing
- Read latency is 0 cycles, as a combinational path from address/`memRead` to `readDataMem`.
- Writes are visible to reads in the cycle after the edge.
- Switch changes are visible at SW 2 cycles after a stable input.
- Reset values:
  - `leds` = 0; CYC = 0; STAT = 0; synchroniser flops = 0.
  - `readDataMem` = 0 when `memRead` is low.
  - RAM contents are not cleared.
- `rst` has priority over any same-cycle write. A store during reset is dropped, and the counter reads 0 on the first cycle after reset.

## Configuration
- `DMEM_MMIO_EN` defined: the MMIO window and its error detection are as above.
- `DMEM_MMIO_EN` undefined:
  - Only RAM exists; every aligned address outside RAM is unmapped, reads 0 and sets the internal bit1 flag.
  - `leds` is tied to 0, and `switches` is unused.
  - CYC and STAT are not readable; the error flags remain only as internal debug state.

## Structure
- Shared package `dmem_pkg`:
  - Address constants `LED_ADDR`, `SW_ADDR`, `CYC_ADDR`, `STAT_ADDR`.
  - STAT bit indices `STAT_MISALIGN`, `STAT_UNMAPPED`.
  - RAM base constant.
- One sub-module `dmem_ram`: word array with combinational read port and edge-triggered write port, parameterised by width and depth. Decode, MMIO registers and error logic live in the top.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0000_0010 -> next cycle, a read of 0x10 returns 0xDEADBEEF, and a read of 0x14 returns the prior RAM contents.
- Write 0x0001_A5A5 to 0xFFFF_0000 -> `leds` = 0xA5A5 the next cycle, and reading LED returns 0x0000_A5A5.
- Drive `switches` = 0x00F0 -> a SW read returns 0 for 2 cycles, then 0x0000_00F0.
- Load from 0x0000_0013 -> `readDataMem` = 0 and STAT = 0x1. Then store to 0x0001_0000 -> STAT = 0x3 and RAM is unchanged. Then write 0x1 to STAT -> STAT = 0x2.
- Let CYC run 100 cycles after reset -> a read returns 100 (±1 per the edge definition). Then write any value to CYC -> next read = 0, following read = 1. Force the counter to 0xFFFF_FFFF -> the next cycle reads 0.
- Assert `rst` in the same cycle as a store of 0x12345678 to 0x20 and of 0xFFFF to LED -> `leds` = 0 and word 0x20 is unchanged.
